// File: rtl/ahb_sram64_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram64_slave
//
// AHB-Lite responder with a 64-bit data bus in front of a single-port
// synchronous SRAM macro. It sits on the slave side of the IFU/LSU master mux.
//
// It handles byte-lane strobes for 8/16/32/64-bit transfers, the read-after-
// write port conflict, programmable read wait states and the two-cycle ERROR
// response.
//
// Parameters
//   AW_SRAM  SRAM word-address width. Words are 64 bits, so the array holds
//            2^AW_SRAM x 8 bytes. Upper HADDR bits alias onto the array.
//   WAIT     Extra read wait states (0..7) after the SRAM read latency.
//
// Ports
//   HCLK, HRESETn     clock (rising edge) and asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY
//                     address-phase inputs from the decoder and master mux
//   HWDATA            write data, valid in the data phase
//   HREADYOUT, HRDATA, HRESP
//                     data-phase response to the master
//   sram_en, sram_we, sram_addr, sram_wdata
//                     SRAM command. sram_we bit i enables byte i.
//   sram_rdata        SRAM read data. It is valid the cycle after a read
//                     enable and is held until the next enable.
// ---------------------------------------------------------------------------
module ahb_sram64_slave #(
  parameter int AW_SRAM = 12,
  parameter int WAIT    = 0
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [63:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [63:0]        HRDATA,
  output logic               HRESP,
  output logic               sram_en,
  output logic [7:0]         sram_we,
  output logic [AW_SRAM-1:0] sram_addr,
  output logic [63:0]        sram_wdata,
  input  logic [63:0]        sram_rdata
);

  localparam logic [2:0] WAIT_LD = 3'(WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDPEND,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e             state_q, state_d;
  logic [AW_SRAM-1:0] addr_q, addr_d;
  logic [7:0]         mask_q, mask_d;
  logic [2:0]         cnt_q, cnt_d;

  // -------------------------------------------------------------------------
  // Address-phase decode
  // -------------------------------------------------------------------------
  logic               accept;
  logic [AW_SRAM-1:0] haddr_word;
  logic [7:0]         lane_base;
  logic [7:0]         lane_mask;
  logic               bad_xfer;
  logic               req_wr;
  logic               req_rd;
  logic               req_err;
  logic               slave_ready;
  logic               rd_done;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign haddr_word = HADDR[AW_SRAM+2:3];

  // NOTE: every signal assigned in an always_comb gets a default on entry.
  // A path that leaves one unassigned would otherwise infer a latch.
  always_comb begin
    lane_base = 8'h00;
    bad_xfer  = 1'b1;
    unique case (HSIZE)
      3'd0: begin lane_base = 8'h01; bad_xfer = 1'b0;           end
      3'd1: begin lane_base = 8'h03; bad_xfer = HADDR[0];       end
      3'd2: begin lane_base = 8'h0F; bad_xfer = |HADDR[1:0];    end
      3'd3: begin lane_base = 8'hFF; bad_xfer = |HADDR[2:0];    end
      default: begin lane_base = 8'h00; bad_xfer = 1'b1;        end
    endcase
  end

  // An aligned transfer never shifts lanes past bit 7, so truncation is safe.
  assign lane_mask = lane_base << HADDR[2:0];

  assign req_err = accept &  bad_xfer;
  assign req_wr  = accept & ~bad_xfer &  HWRITE;
  assign req_rd  = accept & ~bad_xfer & ~HWRITE;

  // A read is complete once its wait counter has drained.
  assign rd_done = (state_q == S_RD) && (cnt_q == 3'd0);

  // The slave can take a new address phase only while its own data phase is
  // completing. The bus-wide HREADY normally guarantees this, but the state
  // is kept safe even if it does not.
  assign slave_ready = (state_q == S_IDLE) || (state_q == S_WR) ||
                       (state_q == S_ERR2) || rd_done;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;

    if (slave_ready && accept) begin
      addr_d = haddr_word;
      mask_d = lane_mask;
    end

    unique case (state_q)
      S_IDLE, S_ERR2: begin
        if (req_err)     state_d = S_ERR1;
        else if (req_wr) state_d = S_WR;
        else if (req_rd) begin
          state_d = S_RD;
          cnt_d   = WAIT_LD;
        end else         state_d = S_IDLE;
      end

      S_WR: begin
        // The SRAM port is busy with this write, so a new read is deferred.
        if (req_err)     state_d = S_ERR1;
        else if (req_wr) state_d = S_WR;
        else if (req_rd) state_d = S_RDPEND;
        else             state_d = S_IDLE;
      end

      S_RDPEND: begin
        state_d = S_RD;
        cnt_d   = WAIT_LD;
      end

      S_RD: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (req_err) begin
          state_d = S_ERR1;
        end else if (req_wr) begin
          state_d = S_WR;
        end else if (req_rd) begin
          state_d = S_RD;
          cnt_d   = WAIT_LD;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ERR1:  state_d = S_ERR2;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  logic       en_raw;
  logic [7:0] we_raw;

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    en_raw    = 1'b0;
    we_raw    = '0;
    sram_addr = addr_q;

    unique case (state_q)
      S_IDLE, S_ERR2: begin
        HRESP = (state_q == S_ERR2);
        // A read with the port free is issued in its own address phase.
        if (req_rd) begin
          en_raw    = 1'b1;
          sram_addr = haddr_word;
        end
      end

      S_WR: begin
        en_raw = 1'b1;
        we_raw = mask_q;
      end

      S_RDPEND: begin
        HREADYOUT = 1'b0;
        en_raw    = 1'b1;
      end

      S_RD: begin
        if (cnt_q != 3'd0) begin
          HREADYOUT = 1'b0;
        end else begin
          HRDATA = sram_rdata;
          if (req_rd) begin
            en_raw    = 1'b1;
            sram_addr = haddr_word;
          end
        end
      end

      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end

      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // Reset gating on the SRAM strobes covers the combinational address-phase
  // issue path. The macro therefore sees no access while HRESETn is low.
  assign sram_en    = en_raw & HRESETn;
  assign sram_we    = we_raw & {8{HRESETn}};
  assign sram_wdata = HWDATA;

  // The upper address bits alias the array, and HTRANS[0] only tells SEQ
  // from NONSEQ. Neither changes this slave's behaviour.
  logic unused_ok;
  assign unused_ok = ^{HADDR[31:AW_SRAM+3], HTRANS[0]};

endmodule

// File: doc/ahb_sram64_slave.md
Name: ahb_sram64_slave

Overview:
AHB-Lite slave (responder) with a 64-bit data bus, fronting a single-port synchronous SRAM macro.
- Sits on the slave side of the EL2 IFU/LSU master mux: accepts the arbitrated HADDR/HTRANS/HWRITE/HSIZE/HWDATA stream and returns HRDATA/HREADYOUT/HRESP.
- Handles byte-lane strobes, read-after-write port conflicts, programmable read wait states and the two-cycle ERROR response.

Parameters:
AW_SRAM, 12, SRAM word-address width (64-bit words; 2^AW_SRAM x 8 bytes).
WAIT, 0, extra read wait states (0..7) added after SRAM read latency.

Ports:
HCLK  in  1  system clock, all logic on rising edge.
HRESETn  in  1  asynchronous active-low reset.
HSEL  in  1  slave select from decoder.
HADDR  in  32  transfer address.
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ.
HWRITE  in  1  1=write.
HSIZE  in  3  0=byte, 1=half, 2=word, 3=dword.
HWDATA  in  64  write data, valid in data phase.
HREADY  in  1  bus-wide ready (previous transfer complete).
HREADYOUT  out  1  this slave's ready.
HRDATA  out  64  read data.
HRESP  out  1  0=OKAY, 1=ERROR.
sram_en  out  1  SRAM access enable.
sram_we  out  8  per-byte write enable (bit i = HWDATA[8i+7:8i]).
sram_addr  out  AW_SRAM  SRAM word address.
sram_wdata  out  64  SRAM write data.
sram_rdata  in  64  SRAM read data; valid the cycle after sram_en & ~|sram_we, held until the next sram_en.

Behaviour:
Reset and clocking:
- Reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, sram_en=0, sram_we=0, internal address/size/mask registers 0.
- Reset asserted mid-transfer: FSM returns to IDLE at once; sram_en/sram_we are forced 0 asynchronously, including their combinational paths; the pending transfer is dropped.

Transfer acceptance and decode:
- Accept = HSEL & HTRANS[1] & HREADY. The address-phase signals are registered only on accept.
- HSEL with HTRANS IDLE/BUSY: zero-wait OKAY, no SRAM access.
- Word address = HADDR[AW_SRAM+2:3]. Upper HADDR bits are ignored, so the array aliases (wraps).
- Lane mask = ((1<<(1<<HSIZE))-1) << HADDR[2:0].
- Error condition: HSIZE>3, or HADDR[2:0] not a multiple of (1<<HSIZE). Such a transfer makes no SRAM access.

FSM states: IDLE, WR, RD, RDPEND, ERR1, ERR2.
- IDLE:
  - Accepted write -> WR.
  - Accepted read with SRAM port free -> RD; sram_en=1 and sram_addr=HADDR word address, combinationally, in the address-phase cycle.
  - Accepted error -> ERR1.
- WR (data phase):
  - sram_en=1, sram_we=mask, sram_addr=registered address, sram_wdata=HWDATA; HREADYOUT=1.
  - Next state follows the same accept decode as IDLE, except a read accepted in this cycle goes to RDPEND because the port is busy.
- RDPEND:
  - Read issued this cycle from the registered address; HREADYOUT=0.
  - Then RD, with the wait counter loaded as for a normal read.
  - Effect: read-after-write returns the newly written data, with one extra wait state.
- RD:
  - Wait counter loads WAIT on issue; HREADYOUT=0 while counter != 0, decrementing each cycle.
  - When the counter is 0: HREADYOUT=1, HRDATA=sram_rdata. Next state per accept decode; reads go directly to RD (port free).
  - Read latency from the address phase is 1+WAIT cycles with no conflict, 2+WAIT after a write.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1. A transfer accepted in this cycle is decoded normally; per AHB-Lite the master normally drives IDLE here.

Output rules:
- HRDATA is 0 when not in RD with HREADYOUT=1.
- HRESP=0 outside ERR1/ERR2.
- sram_we is nonzero only in WR.
- Back-to-back NONSEQ/SEQ reads with WAIT=0 sustain 1 transfer per cycle.

Test Plan:
1. Reset low mid-read; release -> HREADYOUT=1, HRESP=0, sram_en=0 on the same edge. First read after reset completes in 1 cycle.
2. Write dword 0x1122334455667788 @0x0000_0008, then byte write 0xAA @0x0000_000B -> sram_we=0xFF, then 0x08. Read @0x8 returns 0x11223344AA667788.
3. Write then immediate read of the same address (WAIT=0) -> read data phase has exactly 1 wait state and returns the new data. Back-to-back reads of 0x0/0x8/0x10 -> HREADYOUT never low.
4. WAIT=3, single read -> HREADYOUT low for 3 cycles, high on the 4th data-phase cycle with correct data.
5. Half-word @0x...1, or HSIZE=4 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1). No sram_en, memory unchanged.
6. AW_SRAM=12: write @0x0000_8000 then read @0x0000_0000 -> same data (alias). HSEL=0 or HREADY=0 with NONSEQ -> no access, HREADYOUT stays 1.
